// File: rtl/rotary_value_controller.sv
// Turns rotary detent pulses into a bounded, saturating setting value with
// speed-up for quick turns, an event queue and a valid/ready publish port.
module rotary_value_controller #(
  parameter int WIDTH       = 8,
  parameter int MIN_VAL     = 0,
  parameter int MAX_VAL     = 255,
  parameter int INIT_VAL    = 128,
  parameter int FAST_WINDOW = 1000000,
  parameter int FAST_STEP   = 8,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rotary_event,
  input  logic             rotary_left,
  input  logic             button_pressed,
  output logic [WIDTH-1:0] value_out,
  output logic             value_valid,
  input  logic             value_ready,
  output logic             overflow_drop
);

  localparam int GAP_W  = $clog2(FAST_WINDOW + 1);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int CALC_W = WIDTH + 2;

  typedef enum logic [1:0] {
    IDLE,
    APPLY,
    PUBLISH
  } state_t;

  state_t           state;
  logic [GAP_W-1:0] gap;
  logic             fast_evt;
  logic             btn_latch;
  logic [1:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic             serve_btn;
  logic             pop;
  logic             evt_ok;
  logic             push;
  logic             drop;
  logic [1:0]       head;
  logic             cur_left;
  logic             cur_fast;
  logic [WIDTH-1:0] next_val;

  // Step and clamp with two guard bits so neither direction can wrap.
  function automatic logic [WIDTH-1:0] clamp_step(input logic [WIDTH-1:0] cur,
                                                  input logic left,
                                                  input logic fast);
    logic signed [CALC_W-1:0] base;
    logic signed [CALC_W-1:0] step;
    logic signed [CALC_W-1:0] nxt;
    logic signed [CALC_W-1:0] lo;
    logic signed [CALC_W-1:0] hi;
    base = signed'({2'b00, cur});
    step = fast ? CALC_W'(FAST_STEP) : CALC_W'(1);
    lo   = CALC_W'(MIN_VAL);
    hi   = CALC_W'(MAX_VAL);
    nxt  = left ? (base - step) : (base + step);
    if (nxt < lo) begin
      nxt = lo;
    end else if (nxt > hi) begin
      nxt = hi;
    end
    return nxt[WIDTH-1:0];
  endfunction

  assign fast_evt  = (gap < GAP_W'(FAST_WINDOW));
  assign full      = (count == CNT_W'(FIFO_DEPTH));
  assign empty     = (count == '0);
  assign serve_btn = (state == IDLE) && btn_latch;
  assign pop       = (state == IDLE) && !btn_latch && !empty;
  assign evt_ok    = rotary_event && !button_pressed;
  assign push      = evt_ok && (!full || pop || serve_btn);
  assign drop      = evt_ok && !push;
  assign head      = mem[rd_ptr];
  assign next_val  = clamp_step(value_out, cur_left, cur_fast);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap <= GAP_W'(FAST_WINDOW);
    end else if (rotary_event) begin
      gap <= '0;
    end else if (gap != GAP_W'(FAST_WINDOW)) begin
      gap <= gap + GAP_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {rotary_left, fast_evt};
    end
  end

  // A button flush drops everything queued but keeps an event pushed in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (serve_btn) begin
      rd_ptr <= wr_ptr;
      wr_ptr <= wr_ptr + PTR_W'(push);
      count  <= CNT_W'(push);
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_latch     <= 1'b0;
      overflow_drop <= 1'b0;
    end else begin
      btn_latch     <= button_pressed | (btn_latch & ~serve_btn);
      overflow_drop <= drop;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      value_out   <= WIDTH'(INIT_VAL);
      value_valid <= 1'b0;
      cur_left    <= 1'b0;
      cur_fast    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (btn_latch) begin
            value_out   <= WIDTH'(INIT_VAL);
            value_valid <= 1'b1;
            state       <= PUBLISH;
          end else if (!empty) begin
            cur_left <= head[1];
            cur_fast <= head[0];
            state    <= APPLY;
          end
        end
        APPLY: begin
          if (next_val != value_out) begin
            value_out   <= next_val;
            value_valid <= 1'b1;
            state       <= PUBLISH;
          end else begin
            state <= IDLE;
          end
        end
        PUBLISH: begin
          if (value_ready) begin
            value_valid <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rotary_value_controller.sv
// Directed bench for rotary_value_controller: stimulus pushes expected published
// values into a queue, a monitor pops and compares on every handshake.
module tb_rotary_value_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rotary_event = 1'b0;
  logic       rotary_left = 1'b0;
  logic       button_pressed = 1'b0;
  logic       value_ready = 1'b0;
  logic [7:0] value_out;
  logic       value_valid;
  logic       overflow_drop;

  int         n_checks = 0;
  int         n_fail = 0;
  int         ovf_count = 0;
  logic [7:0] exp_q[$];

  rotary_value_controller #(
    .WIDTH(8), .MIN_VAL(0), .MAX_VAL(255), .INIT_VAL(128),
    .FAST_WINDOW(50), .FAST_STEP(8), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .rotary_event(rotary_event),
    .rotary_left(rotary_left),
    .button_pressed(button_pressed),
    .value_out(value_out),
    .value_valid(value_valid),
    .value_ready(value_ready),
    .overflow_drop(overflow_drop)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Handshake completes on the following rising edge.
  always @(negedge clk) begin
    logic [7:0] e;
    if (rst_n) begin
      if (overflow_drop) ovf_count++;
      if (value_valid && value_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_publish: got %0d, expected no publish", value_out);
        end else begin
          e = exp_q.pop_front();
          check("publish", int'(value_out), int'(e));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic evt(input logic left);
    rotary_event = 1'b1;
    rotary_left  = left;
    tick();
    rotary_event = 1'b0;
    rotary_left  = 1'b0;
  endtask

  task automatic press();
    button_pressed = 1'b1;
    tick();
    button_pressed = 1'b0;
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      tick();
      t++;
    end
    check(name, exp_q.size(), 0);
    tick(2);
  endtask

  initial begin
    int v;
    int ovf_base;

    // Reset state
    tick(2);
    check("reset_value", int'(value_out), 128);
    check("reset_valid", int'(value_valid), 0);
    check("reset_ovf", int'(overflow_drop), 0);
    rst_n = 1'b1;
    value_ready = 1'b1;
    tick(2);

    // 1: three slow right events
    exp_q.push_back(8'd129); evt(1'b0); tick(60);
    exp_q.push_back(8'd130); evt(1'b0); tick(60);
    exp_q.push_back(8'd131); evt(1'b0);
    drain("t1_drain");

    // 2: slow then fast left from 128
    tick(60);
    exp_q.push_back(8'd128); press(); drain("t2_button");
    tick(60);
    exp_q.push_back(8'd127); evt(1'b1); tick(9);
    exp_q.push_back(8'd119); evt(1'b1);
    drain("t2_drain");

    // 3: climb to 250, fast step saturates at 255, then no publish
    exp_q.push_back(8'd128); press(); drain("t3_button");
    tick(60);
    exp_q.push_back(8'd129); evt(1'b0); tick(60);
    exp_q.push_back(8'd130); evt(1'b0);
    v = 130;
    for (int i = 0; i < 15; i++) begin
      tick(3);
      v = v + 8;
      exp_q.push_back(8'(v));
      evt(1'b0);
    end
    drain("t3_climb");
    check("t3_at_250", int'(value_out), 250);
    tick(3);
    exp_q.push_back(8'd255); evt(1'b0);
    drain("t3_sat");
    check("t3_at_255", int'(value_out), 255);
    tick(3); evt(1'b0); tick(10);
    check("t3_no_pub_hi_valid", int'(value_valid), 0);
    check("t3_no_pub_hi_value", int'(value_out), 255);

    // 3b: mirror at MIN_VAL
    exp_q.push_back(8'd128); press(); drain("t3b_button");
    v = 128;
    for (int i = 0; i < 16; i++) begin
      tick(3);
      v = v - 8;
      exp_q.push_back(8'(v));
      evt(1'b1);
    end
    drain("t3b_descend");
    check("t3b_at_0", int'(value_out), 0);
    tick(3); evt(1'b1); tick(10);
    check("t3b_no_pub_lo_valid", int'(value_valid), 0);
    check("t3b_no_pub_lo_value", int'(value_out), 0);

    // 4: stalled consumer, six events back to back
    exp_q.push_back(8'd128); press(); drain("t4_button");
    tick(60);
    ovf_base = ovf_count;
    value_ready = 1'b0;
    exp_q.push_back(8'd129);
    exp_q.push_back(8'd137);
    exp_q.push_back(8'd145);
    exp_q.push_back(8'd153);
    exp_q.push_back(8'd161);
    repeat (6) evt(1'b0);
    tick(5);
    check("t4_stall_valid", int'(value_valid), 1);
    check("t4_stall_value", int'(value_out), 129);
    check("t4_drop_count", ovf_count - ovf_base, 1);
    value_ready = 1'b1;
    drain("t4_drain");
    check("t4_final", int'(value_out), 161);

    // 5: button with coincident event flushes three queued entries
    tick(60);
    ovf_base = ovf_count;
    value_ready = 1'b0;
    exp_q.push_back(8'd162);
    repeat (4) evt(1'b0);
    button_pressed = 1'b1;
    rotary_event = 1'b1;
    tick();
    button_pressed = 1'b0;
    rotary_event = 1'b0;
    exp_q.push_back(8'd128);
    tick(3);
    value_ready = 1'b1;
    drain("t5_drain");
    tick(20);
    check("t5_value", int'(value_out), 128);
    check("t5_no_drop", ovf_count - ovf_base, 0);

    // 6: reset while publishing with entries queued
    tick(60);
    value_ready = 1'b0;
    repeat (3) evt(1'b0);
    tick(3);
    check("t6_pre_valid", int'(value_valid), 1);
    ovf_base = ovf_count;
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", int'(value_valid), 0);
    check("t6_rst_value", int'(value_out), 128);
    check("t6_rst_ovf", int'(overflow_drop), 0);
    tick(2);
    rst_n = 1'b1;
    value_ready = 1'b1;
    tick(20);
    exp_q.push_back(8'd129); evt(1'b0);
    drain("t6_after");
    check("t6_no_drop", ovf_count - ovf_base, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
